// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, AXI response codes and helpers shared by the CLINT
// Contents:
//   CLINT_*_OFS     byte offsets of msip, mtimecmp and mtime within the CLINT window
//   AXI_RESP_*      AXI response encodings
//   clint_sel_e     decoded register select
//   clint_div       clock-to-timebase divider
//   clint_decode    maps addr[15:3] to a register select
//   byte_merge      byte-lane update of a 64-bit register
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_MTIMECMP,
        SEL_MTIME
    } clint_sel_e;

    function automatic int clint_div(input int clk_hz, input int tb_hz);
        return clk_hz / tb_hz;
    endfunction

    function automatic clint_sel_e clint_decode(input logic [12:0] a);
        return a == CLINT_MSIP_OFS[15:3]     ? SEL_MSIP :
               a == CLINT_MTIMECMP_OFS[15:3] ? SEL_MTIMECMP :
               a == CLINT_MTIME_OFS[15:3]    ? SEL_MTIME : SEL_NONE;
    endfunction

    function automatic logic [63:0] byte_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                               input logic [7:0] strb);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/clint_timebase.sv
// clint_timebase: prescaler and 64-bit mtime counter with byte-wise bus write
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en             bus write to mtime this cycle (wins over a tick on the same edge)
//   wr_data, wr_strb  write data and byte enables
//   mtime             current mtime value
module clint_timebase
    import clint_pkg::*;
#(
    parameter int DIV = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_strb,
    output logic [63:0] mtime
);

    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [63:0]   mtime_q, mtime_d;
    logic          tick;

    // The prescaler free-runs; an mtime write drops the coincident tick but
    // leaves the prescaler phase alone.
    always_comb begin
        tick    = pre_q == PW'(DIV - 1);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        mtime_d = wr_en ? byte_merge(mtime_q, wr_data, wr_strb) :
                  tick  ? mtime_q + 64'd1 : mtime_q;
        mtime   = mtime_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            mtime_q <= '0;
        end else begin
            pre_q   <= pre_d;
            mtime_q <= mtime_d;
        end
    end

endmodule

// File: rtl/axi_clint.sv
// axi_clint: AXI4 (single-beat, 64-bit) core-local interruptor holding msip, mtimecmp and mtime
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*            write address/data/response channels
//   s_ar*/s_r*                 read address/data channels
//   rdtime                     current mtime
//   irq_m_timer                registered mtime >= mtimecmp
//   irq_m_software             msip
// Build option: AXI_CLINT_RESP_ERR_EN makes unmapped accesses answer SLVERR.
module axi_clint
    import clint_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TIMEBASE_HZ = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [2:0]  s_awsize,
    input  logic [3:0]  s_awcache,
    input  logic [2:0]  s_awprot,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [63:0] s_wdata,
    input  logic [7:0]  s_wstrb,
    input  logic        s_wlast,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [2:0]  s_arsize,
    input  logic [3:0]  s_arcache,
    input  logic [2:0]  s_arprot,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [63:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic [63:0] rdtime,
    output logic        irq_m_timer,
    output logic        irq_m_software
);

    localparam int DIV = clint_div(CLK_FREQ_HZ, TIMEBASE_HZ);
`ifdef AXI_CLINT_RESP_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        aw_full_q, aw_full_d;
    logic [12:0] aw_addr_q, aw_addr_d;
    logic        w_full_q, w_full_d;
    logic [63:0] w_data_q, w_data_d;
    logic [7:0]  w_strb_q, w_strb_d;
    logic        b_valid_q, b_valid_d;
    logic [1:0]  b_resp_q, b_resp_d;
    logic        r_valid_q, r_valid_d;
    logic [63:0] r_data_q, r_data_d;
    logic [1:0]  r_resp_q, r_resp_d;
    logic        msip_q, msip_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q, irq_d;
    logic        aw_hs, w_hs, ar_hs, b_hs, commit, mtime_we;
    clint_sel_e  wsel, rsel;
    logic [63:0] mtime;
    logic        unused_ok;

    clint_timebase #(.DIV(DIV)) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mtime_we),
        .wr_data (w_data_q),
        .wr_strb (w_strb_q),
        .mtime   (mtime)
    );

    always_comb begin
        s_awready  = !aw_full_q && !b_valid_q;
        s_wready   = !w_full_q && !b_valid_q;
        s_arready  = !r_valid_q;
        aw_hs      = s_awvalid && s_awready;
        w_hs       = s_wvalid && s_wready;
        ar_hs      = s_arvalid && s_arready;
        b_hs       = b_valid_q && s_bready;
        // Both slots full and no response outstanding: apply the write now.
        commit     = aw_full_q && w_full_q && !b_valid_q;
        wsel       = clint_decode(aw_addr_q);
        rsel       = clint_decode(s_araddr[15:3]);
        aw_full_d  = b_hs ? 1'b0 : aw_hs ? 1'b1 : aw_full_q;
        aw_addr_d  = aw_hs ? s_awaddr[15:3] : aw_addr_q;
        w_full_d   = b_hs ? 1'b0 : w_hs ? 1'b1 : w_full_q;
        w_data_d   = w_hs ? s_wdata : w_data_q;
        w_strb_d   = w_hs ? s_wstrb : w_strb_q;
        b_valid_d  = commit ? 1'b1 : b_hs ? 1'b0 : b_valid_q;
        b_resp_d   = commit ? ((ERR_EN && wsel == SEL_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY) : b_resp_q;
        msip_d     = (commit && wsel == SEL_MSIP && w_strb_q[0]) ? w_data_q[0] : msip_q;
        mtimecmp_d = (commit && wsel == SEL_MTIMECMP) ? byte_merge(mtimecmp_q, w_data_q, w_strb_q) : mtimecmp_q;
        mtime_we   = commit && wsel == SEL_MTIME;
        irq_d      = mtime >= mtimecmp_q;
        r_valid_d  = ar_hs ? 1'b1 : (r_valid_q && s_rready) ? 1'b0 : r_valid_q;
        // Read data comes from the current registers, so a read racing a
        // commit on the same edge sees the pre-write value.
        r_data_d   = !ar_hs ? r_data_q :
                     rsel == SEL_MSIP     ? {63'd0, msip_q} :
                     rsel == SEL_MTIMECMP ? mtimecmp_q :
                     rsel == SEL_MTIME    ? mtime : 64'd0;
        r_resp_d   = !ar_hs ? r_resp_q : (ERR_EN && rsel == SEL_NONE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        s_bvalid       = b_valid_q;
        s_bresp        = b_resp_q;
        s_rvalid       = r_valid_q;
        s_rdata        = r_data_q;
        s_rresp        = r_resp_q;
        s_rlast        = 1'b1;
        rdtime         = mtime;
        irq_m_timer    = irq_q;
        irq_m_software = msip_q;
        unused_ok      = ^{s_awaddr[31:16], s_awaddr[2:0], s_araddr[31:16], s_araddr[2:0],
                           s_awsize, s_awcache, s_awprot, s_arsize, s_arcache, s_arprot, s_wlast};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= AXI_RESP_OKAY;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= AXI_RESP_OKAY;
            msip_q     <= 1'b0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            msip_q     <= msip_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_axi_clint.sv
// tb_axi_clint: randomized and directed checks of axi_clint (DIV=100 and DIV=1 instances share one bus)
module tb_axi_clint;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        s_awvalid = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_wvalid = 1'b0;
    logic [63:0] s_wdata = '0;
    logic [7:0]  s_wstrb = '0;
    logic        s_bready = 1'b0;
    logic        s_arvalid = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_rready = 1'b0;

    logic        awready_o [2];
    logic        wready_o [2];
    logic        bvalid_o [2];
    logic [1:0]  bresp_o [2];
    logic        arready_o [2];
    logic        rvalid_o [2];
    logic [63:0] rdata_o [2];
    logic [1:0]  rresp_o [2];
    logic        rlast_o [2];
    logic [63:0] rdtime_o [2];
    logic        irq_t_o [2];
    logic        irq_s_o [2];

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        axi_clint #(.CLK_FREQ_HZ(g == 0 ? 100_000_000 : 1_000_000), .TIMEBASE_HZ(1_000_000)) u_dut (
            .clk(clk), .reset(reset),
            .s_awvalid(s_awvalid), .s_awready(awready_o[g]), .s_awaddr(s_awaddr),
            .s_awsize(3'd3), .s_awcache(4'd0), .s_awprot(3'd0),
            .s_wvalid(s_wvalid), .s_wready(wready_o[g]), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(1'b1),
            .s_bvalid(bvalid_o[g]), .s_bready(s_bready), .s_bresp(bresp_o[g]),
            .s_arvalid(s_arvalid), .s_arready(arready_o[g]), .s_araddr(s_araddr),
            .s_arsize(3'd3), .s_arcache(4'd0), .s_arprot(3'd0),
            .s_rvalid(rvalid_o[g]), .s_rready(s_rready), .s_rdata(rdata_o[g]), .s_rresp(rresp_o[g]),
            .s_rlast(rlast_o[g]),
            .rdtime(rdtime_o[g]), .irq_m_timer(irq_t_o[g]), .irq_m_software(irq_s_o[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Behavioural model: mtime is the last written value plus the number of
    // prescaler wraps (every DIV-th edge since reset) that happened after the
    // write edge; the write edge's own wrap is swallowed by the write.
    longint unsigned divs [2] = '{100, 1};
    longint unsigned e_n = 0;
    longint unsigned w_e = 0;
    logic [63:0] w_v [2] = '{64'd0, 64'd0};
    logic [63:0] m_mt [2] = '{64'd0, 64'd0};
    logic [63:0] prev_mt [2];
    logic [63:0] m_cmp = '1;
    logic        m_msip = 1'b0;
    logic        m_irq [2] = '{1'b0, 1'b0};
    bit          wr_pend = 0;
    longint unsigned wr_at = 0;
    logic [31:0] wr_a;
    logic [63:0] wr_d;
    logic [7:0]  wr_s;

    logic [63:0] tmp_ex [2];
    logic [63:0] got;
    logic [31:0] ra;
    logic [63:0] rv;
    logic [7:0]  rs;

    function automatic int kind(input logic [31:0] a);
        return a[15:3] == 13'h0000 ? 1 : a[15:3] == 13'h0800 ? 2 : a[15:3] == 13'h17FF ? 3 : 0;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
        return o;
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a);
`ifdef AXI_CLINT_RESP_ERR_EN
        return kind(a) == 0 ? 2'b10 : 2'b00;
`else
        return kind(a) == 0 ? 2'b00 : 2'b00;
`endif
    endfunction

    function automatic logic [63:0] rd_model(input int i, input logic [31:0] a);
        case (kind(a))
            1: return {63'd0, m_msip};
            2: return m_cmp;
            3: return m_mt[i];
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            e_n = 0; w_e = 0; m_cmp = '1; m_msip = 1'b0; wr_pend = 0;
            for (int i = 0; i < 2; i++) begin
                w_v[i] = '0; m_mt[i] = '0; m_irq[i] = 1'b0;
            end
        end else begin
            e_n++;
            for (int i = 0; i < 2; i++) begin
                m_irq[i] = m_mt[i] >= m_cmp;
                prev_mt[i] = m_mt[i];
                m_mt[i] = w_v[i] + 64'(e_n / divs[i] - w_e / divs[i]);
            end
            if (wr_pend && e_n == wr_at) begin
                wr_pend = 0;
                if (kind(wr_a) == 1 && wr_s[0]) m_msip = wr_d[0];
                if (kind(wr_a) == 2) m_cmp = merge(m_cmp, wr_d, wr_s);
                if (kind(wr_a) == 3) begin
                    w_e = e_n;
                    for (int i = 0; i < 2; i++) begin
                        w_v[i] = merge(prev_mt[i], wr_d, wr_s);
                        m_mt[i] = w_v[i];
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset)
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rdtime%0d", i), rdtime_o[i], m_mt[i]);
                chk($sformatf("irq_timer%0d", i), 64'(irq_t_o[i]), 64'(m_irq[i]));
                chk($sformatf("irq_sw%0d", i), 64'(irq_s_o[i]), 64'(m_msip));
                chk($sformatf("rlast%0d", i), 64'(rlast_o[i]), 64'd1);
            end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic sched(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        wr_pend = 1; wr_at = e_n + 1; wr_a = a; wr_d = d; wr_s = s;
    endtask

    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW.
    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                      input int lead, input int bdly);
        int n;
        n = lead < 0 ? -lead : lead;
        for (int i = 0; i < 2; i++) begin
            chk("awready_idle", 64'(awready_o[i]), 64'd1);
            chk("wready_idle", 64'(wready_o[i]), 64'd1);
        end
        if (lead >= 0) begin s_awvalid = 1; s_awaddr = a; end
        if (lead <= 0) begin s_wvalid = 1; s_wdata = d; s_wstrb = s; end
        step;
        if (n > 0) begin
            s_awvalid = 0; s_wvalid = 0;
            repeat (n - 1) begin
                for (int i = 0; i < 2; i++) chk("no_b_half", 64'(bvalid_o[i]), 64'd0);
                step;
            end
            for (int i = 0; i < 2; i++) begin
                chk("no_b_half", 64'(bvalid_o[i]), 64'd0);
                chk("slot_full", 64'(lead > 0 ? awready_o[i] : wready_o[i]), 64'd0);
            end
            if (lead > 0) begin s_wvalid = 1; s_wdata = d; s_wstrb = s; end
            else begin s_awvalid = 1; s_awaddr = a; end
            step;
        end
        s_awvalid = 0; s_wvalid = 0;
        sched(a, d, s);
        for (int i = 0; i < 2; i++) chk("b_early", 64'(bvalid_o[i]), 64'd0);
        step;
        for (int i = 0; i < 2; i++) begin
            chk("bvalid", 64'(bvalid_o[i]), 64'd1);
            chk("bresp", 64'(bresp_o[i]), 64'(resp_of(a)));
            chk("awready_bpend", 64'(awready_o[i]), 64'd0);
            chk("wready_bpend", 64'(wready_o[i]), 64'd0);
        end
        repeat (bdly) begin
            step;
            for (int i = 0; i < 2; i++) chk("bvalid_hold", 64'(bvalid_o[i]), 64'd1);
        end
        s_bready = 1; step; s_bready = 0;
        for (int i = 0; i < 2; i++) begin
            chk("b_done", 64'(bvalid_o[i]), 64'd0);
            chk("awready_after", 64'(awready_o[i]), 64'd1);
        end
    endtask

    task automatic rd(input logic [31:0] a, input int rdly, output logic [63:0] res);
        logic [63:0] ex [2];
        for (int i = 0; i < 2; i++) begin
            ex[i] = rd_model(i, a);
            chk("arready_idle", 64'(arready_o[i]), 64'd1);
        end
        s_arvalid = 1; s_araddr = a;
        step;
        s_arvalid = 0;
        res = rdata_o[0];
        for (int i = 0; i < 2; i++) begin
            chk("rvalid", 64'(rvalid_o[i]), 64'd1);
            chk("rdata", rdata_o[i], ex[i]);
            chk("rresp", 64'(rresp_o[i]), 64'(resp_of(a)));
            chk("arready_busy", 64'(arready_o[i]), 64'd0);
        end
        repeat (rdly) begin
            step;
            for (int i = 0; i < 2; i++) begin
                chk("rvalid_hold", 64'(rvalid_o[i]), 64'd1);
                chk("rdata_stable", rdata_o[i], ex[i]);
                chk("arready_hold", 64'(arready_o[i]), 64'd0);
            end
        end
        s_rready = 1; step; s_rready = 0;
        for (int i = 0; i < 2; i++) begin
            chk("r_done", 64'(rvalid_o[i]), 64'd0);
            chk("arready_after", 64'(arready_o[i]), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdtime", rdtime_o[i], 64'd0);
            chk("rst_irq_t", 64'(irq_t_o[i]), 64'd0);
            chk("rst_irq_s", 64'(irq_s_o[i]), 64'd0);
            chk("rst_bvalid", 64'(bvalid_o[i]), 64'd0);
            chk("rst_rvalid", 64'(rvalid_o[i]), 64'd0);
            chk("rst_awready", 64'(awready_o[i]), 64'd1);
            chk("rst_wready", 64'(wready_o[i]), 64'd1);
            chk("rst_arready", 64'(arready_o[i]), 64'd1);
            chk("rst_rdata", rdata_o[i], 64'd0);
            chk("rst_bresp", 64'(bresp_o[i]), 64'd0);
            chk("rst_rresp", 64'(rresp_o[i]), 64'd0);
        end
        while (e_n < 1000) step;
        chk("run1000_div100", rdtime_o[0], 64'd10);
        chk("run1000_div1", rdtime_o[1], 64'd1000);
        chk("run1000_irq", 64'(irq_t_o[0]), 64'd0);

        do_reset;
        wr(32'h4000, 64'd5, 8'hFF, 0, 0);
        while (e_n < 500) step;
        chk("mtime_at5", rdtime_o[0], 64'd5);
        chk("irq_lag", 64'(irq_t_o[0]), 64'd0);
        step;
        chk("irq_rise", 64'(irq_t_o[0]), 64'd1);

        wr(32'h0000, 64'd1, 8'hFF, 3, 1);
        chk("msip_set", 64'(irq_s_o[0]), 64'd1);
        wr(32'h0000, 64'd0, 8'hFF, 0, 0);
        chk("msip_clr", 64'(irq_s_o[0]), 64'd0);

        rd(32'hBFF8, 4, got);

        // mtime write committing on the same edge as a read of mtime
        s_awvalid = 1; s_awaddr = 32'hBFF8;
        s_wvalid = 1; s_wdata = 64'hFFFF_FFFF_FFFF_FFFE; s_wstrb = 8'hFF;
        step;
        s_awvalid = 0; s_wvalid = 0;
        sched(32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        for (int i = 0; i < 2; i++) tmp_ex[i] = m_mt[i];
        s_arvalid = 1; s_araddr = 32'hBFF8;
        step;
        s_arvalid = 0;
        for (int i = 0; i < 2; i++) begin
            chk("rd_pre_write", rdata_o[i], tmp_ex[i]);
            chk("b_with_read", 64'(bvalid_o[i]), 64'd1);
        end
        chk("mtime_written", rdtime_o[1], 64'hFFFF_FFFF_FFFF_FFFE);
        step;
        chk("mtime_max", rdtime_o[1], 64'hFFFF_FFFF_FFFF_FFFF);
        step;
        chk("mtime_wrap", rdtime_o[1], 64'd0);
        s_bready = 1; s_rready = 1; step; s_bready = 0; s_rready = 0;
        chk("b_r_done", 64'(bvalid_o[0] | rvalid_o[0]), 64'd0);

        wr(32'h4000, 64'h1111_2222_3333_4444, 8'hFF, 0, 0);
        wr(32'h4000, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, -1, 0);
        rd(32'h4000, 0, got);
        chk("cmp_low_half", got, 64'h1111_2222_CCCC_DDDD);
        wr(32'hBFF8, 64'h1234_5678_0000_0000, 8'hFF, 0, 0);
        wr(32'hBFF8, 64'h0, 8'h0F, 0, 0);
        chk("mtime_upper_kept", 64'(rdtime_o[1][63:32]), 64'h1234_5678);

        rd(32'h1000, 0, got);
        chk("unmapped_rdata", got, 64'd0);

        repeat (150) begin
            case ($urandom_range(0, 5))
                0: ra = 32'h0000;
                1: ra = 32'h4000;
                2: ra = 32'hBFF8;
                3: ra = 32'h1000;
                4: ra = {16'h0, 13'($urandom), 3'b000};
                default: ra = 32'h4004;
            endcase
            rv = kind(ra) == 2 ? m_mt[0] + 64'($urandom_range(0, 40)) : {$urandom, $urandom};
            rs = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 1))
                wr(ra, rv, rs, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)));
            else
                rd(ra, int'($urandom_range(0, 3)), got);
            repeat ($urandom_range(0, 2)) step;
        end

        // reset with a write response and a read response both pending
        s_awvalid = 1; s_awaddr = 32'h0000;
        s_wvalid = 1; s_wdata = 64'd1; s_wstrb = 8'hFF;
        s_arvalid = 1; s_araddr = 32'h4000;
        step;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        sched(32'h0000, 64'd1, 8'hFF);
        step;
        chk("pre_rst_bvalid", 64'(bvalid_o[0]), 64'd1);
        chk("pre_rst_rvalid", 64'(rvalid_o[0]), 64'd1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_bvalid", 64'(bvalid_o[i]), 64'd0);
            chk("midrst_rvalid", 64'(rvalid_o[i]), 64'd0);
            chk("midrst_awready", 64'(awready_o[i]), 64'd1);
            chk("midrst_wready", 64'(wready_o[i]), 64'd1);
            chk("midrst_arready", 64'(arready_o[i]), 64'd1);
        end
        step;
        step;
        reset = 1'b0;
        repeat (3) begin
            step;
            for (int i = 0; i < 2; i++) chk("no_resp_after_rst", 64'(bvalid_o[i] | rvalid_o[i]), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
